mult_iter: RTL and testbench
============================

Name: mult_iter

Overview:
Iterative 32x32 multiplier for the MULT/MULTU instructions. It produces a full 64-bit product split into HI and LO words, and feeds the HI/LO registers next to the single-cycle low-word MUL path. It uses a radix-2 shift-add datapath over unsigned magnitudes, with a final sign-correction cycle. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits, split as hi/lo of WIDTH each.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin a multiply; sampled on a rising edge
signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when hi/lo are updated
hi  output  WIDTH  upper word of the last completed product
lo  output  WIDTH  lower word of the last completed product

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-high. While reset is asserted:
  - state=IDLE
  - busy=0, done=0, hi=0, lo=0
  - all internal registers = 0
- States: IDLE, CALC, FIX, DONE.
- Accept condition: start=1 on an edge while state is IDLE or DONE. On accept:
  - latch mag_a = (signed_op & a[MSB]) ? -a : a
  - latch mag_b = (signed_op & b[MSB]) ? -b : b
  - latch neg = signed_op & (a[MSB] ^ b[MSB])
  - clear the 2*WIDTH accumulator
  - load the iteration counter with WIDTH
  - go to CALC
- CALC, one bit per cycle:
  - if mag_b[0], acc += mag_a shifted left by the current bit index (equivalently, use a shifting multiplicand register)
  - shift mag_b right by 1, decrement the counter
  - when the counter reaches 0 after the update, go to FIX
  - CALC lasts exactly WIDTH cycles
- FIX: result = neg ? -acc (2*WIDTH-bit two's complement) : acc. Then go to DONE.
- DONE:
  - exactly one cycle
  - hi/lo registered from the result on the FIX->DONE edge
  - done=1
  - next state is CALC if start is accepted, otherwise IDLE
- Latency: with start accepted at edge T, busy=1 from T through the CALC/FIX cycles, hi/lo update and done=1 on the cycle after edge T+WIDTH+1 (T+33 for WIDTH=32). Throughput is one product per WIDTH+2 cycles.
- busy = 1 in CALC and FIX only. It is 0 in IDLE and DONE.
- done = 1 in DONE only, and is registered.
- start while busy=1 is ignored entirely: no latch, no effect on the running op, no queueing.
- hi/lo hold their value until the next DONE. They change only on the FIX->DONE transition.
- Arithmetic boundaries:
  - the accumulator is 2*WIDTH bits; no overflow is possible for unsigned magnitudes
  - in signed mode, -(0x80000000) is handled as unsigned magnitude 0x80000000 (correct)
  - zero operands still take the full WIDTH cycles (no early exit)
  - a negative times zero yields 0: the negation of 0 is 0
- Reset mid-operation: the operation is aborted immediately, hi/lo are cleared to 0, and no done pulse is produced.

Test Plan:
1. signed_op=1, a=0xFFFFFFFD (-3), b=5 -> done 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
2. signed_op=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with signed_op=1 -> hi=0x00000000, lo=0x00000001.
3. signed_op=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
4. Accept 7*6, then pulse start with a=b=2 at cycle 10 while busy -> that start is ignored; hi=0, lo=42; state returns to IDLE after DONE.
5. Hold start=1 with new operands (12, 0xFFFFFFFF signed) in the DONE cycle of a previous op -> accepted back-to-back; busy rises the next cycle; second result hi=0xFFFFFFFF, lo=0xFFFFFFF4.
6. Assert reset asynchronously (mid-cycle) 15 cycles into an op -> busy, done, hi, lo go to 0 immediately; no done pulse follows; the next op after release computes correctly.

Source files
------------

// File: rtl/mult_iter.sv
// Iterative radix-2 shift-add multiplier producing a full 2*WIDTH-bit product
// as hi/lo words. Operands are reduced to unsigned magnitudes on accept, the
// product is built one multiplier bit per cycle, and a final cycle applies
// the sign. A new operation may be accepted from IDLE or from the DONE cycle.
module mult_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic                   neg_q, neg_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    logic                   accept;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [2*WIDTH-1:0]     result;

    // Operand magnitudes and signed result; -(most negative) keeps its bit
    // pattern, which is exactly the correct unsigned magnitude.
    always_comb begin
        abs_a  = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b  = (signed_op && b[WIDTH-1]) ? -b : b;
        result = neg_q ? -acc_q : acc_q;
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    neg_d    = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears hi/lo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_iter.sv
// Self-checking bench for mult_iter: directed corner cases plus randomized
// operands compared against a plain-arithmetic 64-bit product model.
module tb_mult_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    mult_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference product computed directly from the operand interpretation.
    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to its DONE cycle (bounded wait).
    // Returns with simulation sitting in the DONE cycle (if it arrived).
    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          output int busy_cycles, output logic done_seen,
                          output logic [63:0] prod);
        signed_op = s;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            tick();
        end
        done_seen = done;
        prod = {hi, lo};
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_async busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_release busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_signed_small();
        int n;
        logic d;
        logic [63:0] p;
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, n, d, p);
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL neg3x5_busy_cycles got=%0d expected=33", n);
        end
        vectors++;
        if (d !== 1'b1) begin
            miscompares++;
            $display("FAIL neg3x5_done got=%b expected=1", d);
        end
        vectors++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            miscompares++;
            $display("FAIL neg3x5_product got=%h expected=ffffffff_fffffff1", p);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL neg3x5_done_pulse done=%b busy=%b expected 0 0", done, busy);
        end
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            miscompares++;
            $display("FAIL neg3x5_hold got=%h expected=ffffffff_fffffff1", {hi, lo});
        end
    endtask

    task automatic test_corners();
        logic        s_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] a_t [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic [63:0] e_t [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                                  64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
        int n;
        logic d;
        logic [63:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(s_t[i], a_t[i], b_t[i], n, d, p);
            vectors++;
            if (p !== e_t[i] || d !== 1'b1 || n !== 33) begin
                miscompares++;
                $display("FAIL corner%0d got prod=%h done=%b cycles=%0d expected prod=%h done=1 cycles=33",
                         i, p, d, n, e_t[i]);
            end
            tick();
        end
        // negative times zero must give zero and still run the full length
        run_op(1'b1, 32'h8000_0005, 32'd0, n, d, p);
        vectors++;
        if (p !== 64'd0 || n !== 33) begin
            miscompares++;
            $display("FAIL neg_times_zero got prod=%h cycles=%0d expected prod=0 cycles=33", p, n);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int n;
        signed_op = 1'b0;
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            start = (n == 10);
            if (n == 10) begin
                a = 32'd2;
                b = 32'd2;
            end
            tick();
        end
        start = 1'b0;
        vectors++;
        if (n !== 33 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_busy_timing cycles=%0d done=%b expected cycles=33 done=1", n, done);
        end
        vectors++;
        if ({hi, lo} !== 64'd42) begin
            miscompares++;
            $display("FAIL ignore_busy_product got=%h expected=42", {hi, lo});
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL ignore_busy_idle busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_busy_no_queue busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic d;
        logic [63:0] p;
        run_op(1'b0, 32'd3, 32'd4, n, d, p);
        vectors++;
        if (p !== 64'd12 || d !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first got prod=%h done=%b expected prod=12 done=1", p, d);
        end
        // issued straight from the DONE cycle
        run_op(1'b1, 32'd12, 32'hFFFF_FFFF, n, d, p);
        vectors++;
        if (n !== 33) begin
            miscompares++;
            $display("FAIL b2b_busy_cycles got=%0d expected=33", n);
        end
        vectors++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFF4 || d !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second got prod=%h done=%b expected prod=ffffffff_fffffff4 done=1", p, d);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int n;
        int pulses;
        logic d;
        logic [63:0] p;
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, n, d, p);
        vectors++;
        if (p !== 64'h0B00_EA4E_242D_2080) begin
            miscompares++;
            $display("FAIL pre_reset_product got=%h expected=0b00ea4e_242d2080", p);
        end
        tick();
        signed_op = 1'b1;
        a = 32'hFFFF_0000;
        b = 32'h0001_2345;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_mid_op busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done activity_cycles=%0d expected=0", pulses);
        end
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0009, n, d, p);
        vectors++;
        if (p !== ref_prod(1'b1, 32'hFFFF_FFF9, 32'h0000_0009) || n !== 33 || d !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_op got prod=%h cycles=%0d done=%b expected prod=%h cycles=33 done=1",
                     p, n, d, ref_prod(1'b1, 32'hFFFF_FFF9, 32'h0000_0009));
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] x;
        logic [31:0] y;
        logic s;
        int n;
        logic d;
        logic [63:0] p;
        logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            e = ref_prod(s, x, y);
            run_op(s, x, y, n, d, p);
            vectors++;
            if (p !== e || n !== 33 || d !== 1'b1) begin
                miscompares++;
                $display("FAIL random%0d s=%b a=%h b=%h got prod=%h cycles=%0d done=%b expected prod=%h cycles=33 done=1",
                         i, s, x, y, p, n, d, e);
            end
            // alternate between idle gaps and back-to-back issue from DONE
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_signed_small();
        test_corners();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
